// File: rtl/buffed_bus_reader.sv
// Receiving end of the buffered tristate bus: masks the sampled bus by the
// per-lane driver enables, queues the words in a small FIFO and hands them to
// a valid/ready consumer. Define BUFFED_BUS_READER_SYNC_EN to add a two-flop
// input register stage ahead of masking and push.
module buffed_bus_reader #(
    parameter int DHiBit   = 7,
    parameter int AddrBits = 2
) (
    input  logic              Clk,
    input  logic              RstN,
    input  logic [DHiBit:0]   DBus,
    input  logic [DHiBit:0]   QEna,
    input  logic              CapEna,
    output logic [DHiBit:0]   DOut,
    output logic              DValid,
    input  logic              DReady,
    output logic              Full,
    output logic              Empty,
    output logic [AddrBits:0] Count,
    output logic              Overflow,
    input  logic              ClrOvf
);

    localparam int Depth = 2 ** AddrBits;
    localparam logic [AddrBits:0] MaxCount = {1'b1, {AddrBits{1'b0}}};

    logic [DHiBit:0]   cap_word;
    logic              cap;
    logic [DHiBit:0]   mem [Depth];
    logic [AddrBits-1:0] wr_ptr;
    logic [AddrBits-1:0] rd_ptr;
    logic              push;
    logic              pop;
    logic              drop;

`ifdef BUFFED_BUS_READER_SYNC_EN
    logic [DHiBit:0] bus_s1, bus_s2, ena_s1, ena_s2;
    logic            cap_s1, cap_s2;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            bus_s1 <= '0;
            bus_s2 <= '0;
            ena_s1 <= '0;
            ena_s2 <= '0;
            cap_s1 <= 1'b0;
            cap_s2 <= 1'b0;
        end else begin
            bus_s1 <= DBus;
            bus_s2 <= bus_s1;
            ena_s1 <= QEna;
            ena_s2 <= ena_s1;
            cap_s1 <= CapEna;
            cap_s2 <= cap_s1;
        end
    end

    // Disabled lanes are forced to 0 after the stage, so X/Z never lands in mem.
    assign cap_word = bus_s2 & ena_s2;
    assign cap      = cap_s2;
`else
    assign cap_word = DBus & QEna;
    assign cap      = CapEna;
`endif

    assign Empty  = (Count == '0);
    assign Full   = (Count == MaxCount);
    assign DValid = ~Empty;
    assign DOut   = Empty ? '0 : mem[rd_ptr];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign pop  = DValid & DReady;
    assign push = cap & (~Full | pop);
    assign drop = cap & Full & ~pop;

    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= cap_word;
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            Count    <= '0;
            Overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   Count <= Count + 1'b1;
                2'b01:   Count <= Count - 1'b1;
                default: Count <= Count;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                Overflow <= 1'b1;
            end else if (ClrOvf) begin
                Overflow <= 1'b0;
            end
        end
    end

endmodule

// File: doc/buffed_bus_reader.md
Name: buffed_bus_reader

Overview:
- Receiving end of the buffered tristate data bus.
- Samples the shared bus on a capture strobe and masks off lanes whose drivers are disabled.
- Queues captured words in a small FIFO.
- Hands words to a downstream consumer over a valid/ready handshake.
- Sits between the bus drivers' tristate outputs and the local consumer logic.

Parameters:
DHiBit, 7, index of the MSB of the data bus; bus width = DHiBit+1
AddrBits, 2, FIFO address width; depth = 2**AddrBits words (default 4)

Ports:
Clk  input  1  system clock; all state changes on posedge
RstN  input  1  asynchronous active-low reset
DBus  input  DHiBit+1  shared tristate bus, as driven by the bus drivers
QEna  input  DHiBit+1  per-lane driver enables, same vector the drivers use
CapEna  input  1  capture strobe; sample bus this cycle
DOut  output  DHiBit+1  head-of-FIFO word
DValid  output  1  DOut holds a valid word
DReady  input  1  consumer accepts DOut this cycle
Full  output  1  FIFO holds 2**AddrBits words
Empty  output  1  FIFO holds 0 words
Count  output  AddrBits+1  words currently held
Overflow  output  1  sticky: a capture was dropped because FIFO was full
ClrOvf  input  1  synchronous clear of Overflow

Behaviour:
- Reset (RstN low, asynchronous): pointers and Count = 0; Empty=1, Full=0, DValid=0, Overflow=0, DOut=0. Reset mid-operation discards all queued words immediately.
- Captured word = DBus & QEna, bitwise. Disabled lanes are stored as 0. X/Z on a disabled lane must never reach the FIFO.
- Push: on posedge when CapEna=1 and the FIFO is not Full, after any same-cycle pop is accounted for.
- Pop: on posedge when DValid=1 and DReady=1. Head advances; DOut shows the next word or 0 if the FIFO becomes empty.
- DValid = ~Empty. DOut is registered or read from the head pointer, never combinational from DBus.
- Latency: word captured at edge N is visible on DOut with DValid=1 after edge N when the FIFO was empty. Otherwise it appears in FIFO order.
- Full + CapEna + pop in the same cycle: both happen. Count stays at max, no overflow.
- Full + CapEna, no pop: word is dropped, Overflow set at that edge, FIFO contents unchanged.
- Empty + CapEna + DReady: push only (DValid was 0), Count -> 1.
- Empty + DReady, no CapEna: no change. DReady with DValid=0 is ignored.
- Pointers wrap modulo 2**AddrBits. Count is the true occupancy 0..2**AddrBits. Full = (Count == 2**AddrBits), Empty = (Count == 0).
- ClrOvf=1 clears Overflow at the edge. If an overflow occurs in the same cycle, set wins (Overflow stays 1).
- CapEna with QEna=0 still pushes an all-zero word. Masking does not suppress the capture.

Optional Feature:
- Macro: BUFFED_BUS_READER_SYNC_EN.
- Defined:
  - DBus, QEna and CapEna pass through a two-flop input register stage before masking and push. The extra flops reset to 0.
  - Capture-to-DValid latency becomes 3 edges (edge N strobe -> valid after edge N+2).
  - The same-cycle rules above apply to the delayed strobe.
- Undefined: inputs are used directly, with 1-edge latency as above.

Test Plan:
- Reset then single capture: RstN low 20ns then high; DBus=8'h77, QEna=8'h0e, CapEna for 1 cycle -> next edge DOut=8'h06, DValid=1, Count=1; pulse DReady -> DValid=0, Empty=1, DOut=8'h00.
- Fill and overflow: DReady=0, QEna=8'hff, capture 8'h11,8'h22,8'h33,8'h44 -> Full=1, Count=4; capture 8'h55 -> Overflow=1, then pops return 11,22,33,44 in order, 55 never appears.
- Full with simultaneous push and pop: FIFO full (11..44), CapEna with DBus=8'hbb and DReady=1 in the same cycle -> Count stays 4, Overflow stays 0, pop order 22,33,44,bb.
- Masked lanes with Z: drive DBus=8'hzz on lanes where QEna=0, QEna=8'hf0, DBus[7:4]=4'hc -> DOut=8'hc0, no X in DOut.
- Mid-operation reset and ClrOvf: with Count=3 and Overflow=1, pulse RstN low asynchronously between edges -> Empty=1, Overflow=0 immediately; separately, ClrOvf=1 with an overflowing capture in the same cycle -> Overflow remains 1.
- With BUFFED_BUS_READER_SYNC_EN: capture 8'he7 at edge N -> DValid first seen 1 after edge N+2, DOut=8'he7.
